clcd_line_arbiter: RTL and testbench

Owns the HD44780-style character LCD bus and shares it between two line-writer clients. After reset it runs the LCD power-up command sequence. It then grants the bus round-robin to clients that request a 16-character line write. For each grant it issues one DDRAM set-address command followed by 16 data bytes, each with a generated LCD_E strobe, instead of driving LCD_E from CLK.

---
 rtl/clcd_pkg.sv | 28 ++
 rtl/clcd_byte_slot.sv | 85 ++++++++
 rtl/clcd_line_arbiter.sv | 179 +++++++++++++++++
 tb/tb_clcd_line_arbiter.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/clcd_pkg.sv
// Shared types and LCD command bytes for the character-LCD line arbiter.
package clcd_pkg;

  typedef enum logic [2:0] {
    ST_INIT_WAIT,
    ST_FUNC_SET,
    ST_DISP_ON,
    ST_ENTRY,
    ST_CLEAR,
    ST_IDLE,
    ST_ADDR,
    ST_CHARS
  } state_e;

  localparam logic [7:0] CMD_FUNC_SET = 8'h3C;
  localparam logic [7:0] CMD_DISP_ON  = 8'h0C;
  localparam logic [7:0] CMD_ENTRY    = 8'h06;
  localparam logic [7:0] CMD_CLEAR    = 8'h01;
  localparam logic [7:0] CMD_LINE0    = 8'h80;
  localparam logic [7:0] CMD_LINE1    = 8'hC0;

  localparam int LINE_CHARS = 16;

  function automatic logic [7:0] line_cmd(input logic line);
    return line ? CMD_LINE1 : CMD_LINE0;
  endfunction

endpackage

// File: rtl/clcd_byte_slot.sv
// One LCD bus byte slot: holds RS/RW/DATA for len cycles and strobes LCD_E
// during slot cycles 1..E_HI. A start on the last cycle chains slots seamlessly.
module clcd_byte_slot #(
  parameter int CNT_W = 8,
  parameter int E_HI  = 12
) (
  input  logic             CLK,
  input  logic             RESETN,
  input  logic             start,
  input  logic [CNT_W-1:0] len,
  input  logic             rs,
  input  logic [7:0]       data_byte,
  output logic             last,
  output logic             lcd_e,
  output logic             lcd_rs,
  output logic             lcd_rw,
  output logic [7:0]       lcd_data
);

  logic             active_q, active_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic             e_q, e_d;
  logic             rs_q, rs_d;
  logic             rw_q, rw_d;
  logic [7:0]       data_q, data_d;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    active_d = active_q;
    cnt_d    = cnt_q;
    len_d    = len_q;
    e_d      = e_q;
    rs_d     = rs_q;
    rw_d     = rw_q;
    data_d   = data_q;
    last     = active_q && (cnt_q == len_q - 1'b1);

    if (start) begin
      active_d = 1'b1;
      cnt_d    = '0;
      len_d    = len;
      rs_d     = rs;
      data_d   = data_byte;
      rw_d     = 1'b0;
      e_d      = 1'b0;
    end else if (active_q) begin
      if (last) begin
        active_d = 1'b0;
        rw_d     = 1'b1;
        e_d      = 1'b0;
      end else begin
        cnt_d = cnt_q + 1'b1;
        e_d   = (cnt_d <= CNT_W'(E_HI));
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge CLK or posedge RESETN) begin
    if (RESETN) begin
      active_q <= 1'b0;
      cnt_q    <= '0;
      len_q    <= '0;
      e_q      <= 1'b0;
      rs_q     <= 1'b0;
      rw_q     <= 1'b1;
      data_q   <= 8'h00;
    end else begin
      active_q <= active_d;
      cnt_q    <= cnt_d;
      len_q    <= len_d;
      e_q      <= e_d;
      rs_q     <= rs_d;
      rw_q     <= rw_d;
      data_q   <= data_d;
    end
  end

  assign lcd_e    = e_q;
  assign lcd_rs   = rs_q;
  assign lcd_rw   = rw_q;
  assign lcd_data = data_q;

endmodule

// File: rtl/clcd_line_arbiter.sv
// HD44780 bus owner: power-up command sequence, then round-robin 16-char
// line writes for two clients, each as one set-address byte plus 16 data bytes.
module clcd_line_arbiter
  import clcd_pkg::*;
#(
  parameter int INIT_WAIT = 70,
  parameter int WR_CYC    = 30,
  parameter int E_HI      = 12,
  parameter int CLR_CYC   = 200
) (
  input  logic         CLK,
  input  logic         RESETN,
  input  logic         REQ0,
  input  logic         LINE0,
  input  logic [127:0] TEXT0,
  input  logic         REQ1,
  input  logic         LINE1,
  input  logic [127:0] TEXT1,
  output logic         GNT0,
  output logic         GNT1,
  output logic         DONE,
  output logic         READY,
  output logic         LCD_E,
  output logic         LCD_RS,
  output logic         LCD_RW,
  output logic [7:0]   LCD_DATA
);

  localparam int MAX_A   = (INIT_WAIT > CLR_CYC) ? INIT_WAIT : CLR_CYC;
  localparam int MAX_CYC = (MAX_A > WR_CYC) ? MAX_A : WR_CYC;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  state_e                     state_q, state_d;
  logic [CNT_W-1:0]           wait_q, wait_d;
  logic [3:0]                 idx_q, idx_d;
  logic [1:0]                 gnt_q, gnt_d;
  logic                       done_q, done_d;
  logic                       ready_q, ready_d;
  logic                       rr_last_q, rr_last_d;
  logic                       line_q, line_d;
  logic [LINE_CHARS-1:0][7:0] text_q, text_d;

  logic             win1;
  logic             slot_start;
  logic [CNT_W-1:0] slot_len;
  logic             slot_rs;
  logic [7:0]       slot_byte;
  logic             slot_last;

  always_comb begin
    state_d    = state_q;
    wait_d     = wait_q;
    idx_d      = idx_q;
    gnt_d      = gnt_q;
    done_d     = 1'b0;
    ready_d    = ready_q;
    rr_last_d  = rr_last_q;
    line_d     = line_q;
    text_d     = text_q;
    slot_start = 1'b0;
    slot_len   = CNT_W'(WR_CYC);
    slot_rs    = 1'b0;
    slot_byte  = 8'h00;
    // Client 1 wins alone, or when both ask and client 0 was served last.
    win1       = REQ1 & (~REQ0 | ~rr_last_q);

    unique case (state_q)
      ST_INIT_WAIT: begin
        if (wait_q == CNT_W'(INIT_WAIT - 1)) begin
          state_d    = ST_FUNC_SET;
          wait_d     = '0;
          slot_start = 1'b1;
          slot_byte  = CMD_FUNC_SET;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      ST_FUNC_SET: if (slot_last) begin
        state_d    = ST_DISP_ON;
        slot_start = 1'b1;
        slot_byte  = CMD_DISP_ON;
      end
      ST_DISP_ON: if (slot_last) begin
        state_d    = ST_ENTRY;
        slot_start = 1'b1;
        slot_byte  = CMD_ENTRY;
      end
      ST_ENTRY: if (slot_last) begin
        state_d    = ST_CLEAR;
        slot_start = 1'b1;
        slot_len   = CNT_W'(CLR_CYC);
        slot_byte  = CMD_CLEAR;
      end
      ST_CLEAR: if (slot_last) begin
        state_d = ST_IDLE;
        ready_d = 1'b1;
      end
      ST_IDLE: if (REQ0 | REQ1) begin
        state_d    = ST_ADDR;
        gnt_d      = win1 ? 2'b10 : 2'b01;
        rr_last_d  = win1;
        line_d     = win1 ? LINE1 : LINE0;
        text_d     = win1 ? TEXT1 : TEXT0;
        slot_start = 1'b1;
        slot_byte  = line_cmd(win1 ? LINE1 : LINE0);
      end
      ST_ADDR: if (slot_last) begin
        state_d    = ST_CHARS;
        idx_d      = '0;
        slot_start = 1'b1;
        slot_rs    = 1'b1;
        slot_byte  = text_q[LINE_CHARS-1];
      end
      ST_CHARS: if (slot_last) begin
        if (idx_q == 4'(LINE_CHARS - 1)) begin
          state_d = ST_IDLE;
          gnt_d   = 2'b00;
          done_d  = 1'b1;
        end else begin
          idx_d      = idx_q + 1'b1;
          slot_start = 1'b1;
          slot_rs    = 1'b1;
          // Char i lives in element 15-i, i.e. the bitwise complement of i.
          slot_byte  = text_q[~idx_d];
        end
      end
      default: state_d = ST_INIT_WAIT;
    endcase
  end

  always_ff @(posedge CLK or posedge RESETN) begin
    if (RESETN) begin
      state_q   <= ST_INIT_WAIT;
      wait_q    <= '0;
      idx_q     <= '0;
      gnt_q     <= 2'b00;
      done_q    <= 1'b0;
      ready_q   <= 1'b0;
      rr_last_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      idx_q     <= idx_d;
      gnt_q     <= gnt_d;
      done_q    <= done_d;
      ready_q   <= ready_d;
      rr_last_q <= rr_last_d;
    end
  end

  // NOTE: the latched line/text are pure data, always written at grant before use, so they carry no reset.
  always_ff @(posedge CLK) begin
    line_q <= line_d;
    text_q <= text_d;
  end

  clcd_byte_slot #(
    .CNT_W (CNT_W),
    .E_HI  (E_HI)
  ) u_slot (
    .CLK       (CLK),
    .RESETN    (RESETN),
    .start     (slot_start),
    .len       (slot_len),
    .rs        (slot_rs),
    .data_byte (slot_byte),
    .last      (slot_last),
    .lcd_e     (LCD_E),
    .lcd_rs    (LCD_RS),
    .lcd_rw    (LCD_RW),
    .lcd_data  (LCD_DATA)
  );

  assign GNT0  = gnt_q[0];
  assign GNT1  = gnt_q[1];
  assign DONE  = done_q;
  assign READY = ready_q;

endmodule

// File: tb/tb_clcd_line_arbiter.sv
// Self-checking bench: bus events are compared against an expected byte/time
// list built from the command sequence and the arbitration rules.
module tb_clcd_line_arbiter;

  localparam int INIT_WAIT = 70;
  localparam int WR_CYC    = 30;
  localparam int E_HI      = 12;
  localparam int CLR_CYC   = 200;
  localparam int XFER      = 17 * WR_CYC;
  localparam int READY_AT  = INIT_WAIT + 3 * WR_CYC + CLR_CYC;

  logic         CLK = 1'b0;
  logic         RESETN = 1'b1;
  logic         REQ0 = 1'b0, LINE0 = 1'b0, REQ1 = 1'b0, LINE1 = 1'b0;
  logic [127:0] TEXT0 = '0, TEXT1 = '0;
  logic         GNT0, GNT1, DONE, READY, LCD_E, LCD_RS, LCD_RW;
  logic [7:0]   LCD_DATA;

  clcd_line_arbiter #(
    .INIT_WAIT (INIT_WAIT),
    .WR_CYC    (WR_CYC),
    .E_HI      (E_HI),
    .CLR_CYC   (CLR_CYC)
  ) dut (
    .CLK      (CLK),
    .RESETN   (RESETN),
    .REQ0     (REQ0),
    .LINE0    (LINE0),
    .TEXT0    (TEXT0),
    .REQ1     (REQ1),
    .LINE1    (LINE1),
    .TEXT1    (TEXT1),
    .GNT0     (GNT0),
    .GNT1     (GNT1),
    .DONE     (DONE),
    .READY    (READY),
    .LCD_E    (LCD_E),
    .LCD_RS   (LCD_RS),
    .LCD_RW   (LCD_RW),
    .LCD_DATA (LCD_DATA)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  typedef struct {
    logic       rs;
    logic [7:0] data;
    int         t;
  } ev_t;

  ev_t obs[$];
  ev_t exp_q[$];

  // Bus monitor: logs each LCD_E rising edge and checks strobe width and RW.
  logic e_prev = 1'b0;
  int   e_w = 0;
  always @(negedge CLK) begin
    if (RESETN) begin
      e_prev <= 1'b0;
      e_w    <= 0;
    end else begin
      if (LCD_E && !e_prev) begin
        obs.push_back('{LCD_RS, LCD_DATA, cyc});
        e_w <= 1;
      end else if (LCD_E) begin
        e_w <= e_w + 1;
      end else if (e_prev) begin
        check("e_width", e_w, E_HI);
      end
      if (LCD_E) check("rw_while_e", LCD_RW, 0);
      if (GNT0 || GNT1) check("gnt_exclusive", GNT0 & GNT1, 0);
      e_prev <= LCD_E;
    end
  end

  function automatic logic [127:0] rand_text();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic expect_init(input int rel);
    ev_t e;
    logic [7:0] cmds [4];
    cmds = '{8'h3C, 8'h0C, 8'h06, 8'h01};
    for (int k = 0; k < 4; k++) begin
      e.rs = 1'b0; e.data = cmds[k]; e.t = rel + INIT_WAIT + 1 + WR_CYC * k;
      exp_q.push_back(e);
    end
  endtask

  task automatic expect_xfer(input logic line, input logic [127:0] text, input int at);
    ev_t e;
    e.rs = 1'b0; e.data = line ? 8'hC0 : 8'h80; e.t = at + 1;
    exp_q.push_back(e);
    for (int i = 0; i < 16; i++) begin
      e.rs = 1'b1; e.data = text[127 - 8 * i -: 8]; e.t = at + 1 + WR_CYC * (i + 1);
      exp_q.push_back(e);
    end
  endtask

  task automatic check_bus(input string tag);
    ev_t o, x;
    check({tag, "_count"}, obs.size(), exp_q.size());
    while (obs.size() > 0 && exp_q.size() > 0) begin
      o = obs.pop_front();
      x = exp_q.pop_front();
      check({tag, "_byte"}, {o.rs, o.data}, {x.rs, x.data});
      check({tag, "_time"}, o.t, x.t);
    end
    obs.delete();
    exp_q.delete();
  endtask

  task automatic wait_ready(input int budget, output int at, output int gnt_seen);
    at = -1; gnt_seen = 0;
    for (int i = 0; i < budget && at < 0; i++) begin
      @(negedge CLK);
      if (GNT0 || GNT1) gnt_seen++;
      if (READY) at = cyc;
    end
    if (at < 0) check("ready_timeout", 1, 0);
  endtask

  task automatic wait_gnt(input int budget, output int who, output int at);
    who = -1; at = -1;
    for (int i = 0; i < budget && who < 0; i++) begin
      @(negedge CLK);
      if (GNT0 || GNT1) begin
        who = GNT1 ? 1 : 0;
        at  = cyc;
      end
    end
    if (who < 0) check("gnt_timeout", 1, 0);
  endtask

  task automatic wait_done(input int budget, output int at);
    int low = 0;
    at = -1;
    for (int i = 0; i < budget && at < 0; i++) begin
      @(negedge CLK);
      if (DONE) at = cyc;
      else if (!(GNT0 || GNT1)) low++;
    end
    if (at < 0) check("done_timeout", 1, 0);
    else begin
      check("gnt_held", low, 0);
      check("gnt_drop_at_done", {GNT1, GNT0}, 0);
      check("idle_bus_at_done", {LCD_E, LCD_RW}, 2'b01);
    end
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) @(negedge CLK);
  endtask

  int rel, rdy, gseen, who, at, done_at, prev_done, exp_who, last;
  logic [1:0] pat;
  logic       win_line;
  logic [127:0] win_text;

  initial begin
    // Reset values.
    repeat (3) @(negedge CLK);
    check("rst_gnt", {GNT1, GNT0}, 0);
    check("rst_done_ready", {DONE, READY}, 0);
    check("rst_e", LCD_E, 0);
    check("rst_rs", LCD_RS, 0);
    check("rst_rw", LCD_RW, 1);
    check("rst_data", LCD_DATA, 0);

    // Power-up sequence with no requests.
    RESETN = 1'b0;
    rel = cyc;
    expect_init(rel);
    wait_ready(READY_AT + 50, rdy, gseen);
    check("ready_cycle", rdy - rel, READY_AT);
    check("no_gnt_in_init", gseen, 0);
    check_bus("init");
    last = 1;

    // Both clients requesting continuously: strict alternation.
    TEXT0 = rand_text(); LINE0 = 1'($urandom);
    TEXT1 = rand_text(); LINE1 = 1'($urandom);
    REQ0 = 1'b1; REQ1 = 1'b1;
    prev_done = -1;
    for (int k = 0; k < 4; k++) begin
      exp_who = 1 - last;
      wait_gnt(2000, who, at);
      check("rr_winner", who, exp_who);
      if (prev_done >= 0) check("rr_idle_gap", at - prev_done, 1);
      win_line = (exp_who == 1) ? LINE1 : LINE0;
      win_text = (exp_who == 1) ? TEXT1 : TEXT0;
      expect_xfer(win_line, win_text, at);
      if (exp_who == 1) begin TEXT1 = rand_text(); LINE1 = ~LINE1; end
      else begin TEXT0 = rand_text(); LINE0 = ~LINE0; end
      if (k == 3) begin REQ0 = 1'b0; REQ1 = 1'b0; end
      wait_done(XFER + 50, done_at);
      check("rr_len", done_at - at, XFER);
      check_bus("rr");
      last = exp_who;
      prev_done = done_at;
    end

    // Single request, fixed text.
    repeat (3) @(negedge CLK);
    TEXT0 = "Hello World     "; LINE0 = 1'b1; REQ0 = 1'b1;
    wait_gnt(2000, who, at);
    check("hello_winner", who, 0);
    expect_xfer(1'b1, "Hello World     ", at);
    REQ0 = 1'b0;
    wait_done(XFER + 50, done_at);
    check("hello_len", done_at - at, XFER);
    check_bus("hello");
    last = 0;

    // Inputs changed and request dropped at char 5.
    TEXT0 = rand_text(); LINE0 = 1'($urandom); REQ0 = 1'b1;
    wait_gnt(2000, who, at);
    check("latch_winner", who, 0);
    expect_xfer(LINE0, TEXT0, at);
    wait_until(at + WR_CYC * 6 + 2);
    TEXT0 = ~TEXT0; LINE0 = ~LINE0; REQ0 = 1'b0;
    wait_done(XFER + 50, done_at);
    check("latch_len", done_at - at, XFER);
    check_bus("latch");

    // Random request patterns against the round-robin model.
    for (int k = 0; k < 3; k++) begin
      pat = 2'($urandom_range(1, 3));
      TEXT0 = rand_text(); LINE0 = 1'($urandom);
      TEXT1 = rand_text(); LINE1 = 1'($urandom);
      REQ0 = pat[0]; REQ1 = pat[1];
      exp_who = (pat == 2'b11) ? (1 - last) : (pat[1] ? 1 : 0);
      wait_gnt(2000, who, at);
      check("rand_winner", who, exp_who);
      expect_xfer(exp_who == 1 ? LINE1 : LINE0, exp_who == 1 ? TEXT1 : TEXT0, at);
      REQ0 = 1'b0; REQ1 = 1'b0;
      wait_done(XFER + 50, done_at);
      check("rand_len", done_at - at, XFER);
      check_bus("rand");
      last = exp_who;
    end

    // Reset during char 8 strobe, with client 1 requesting through init.
    TEXT0 = rand_text(); LINE0 = 1'($urandom); REQ0 = 1'b1;
    REQ1 = 1'b0;
    wait_gnt(2000, who, at);
    check("abort_winner", who, 0);
    REQ0 = 1'b0;
    wait_until(at + WR_CYC * 9 + 3);
    check("abort_e_before", LCD_E, 1);
    #2 RESETN = 1'b1;
    #1;
    check("abort_e", LCD_E, 0);
    check("abort_gnt0", GNT0, 0);
    check("abort_rw", LCD_RW, 1);
    TEXT1 = rand_text(); LINE1 = 1'b0; REQ1 = 1'b1;
    repeat (2) @(negedge CLK);
    obs.delete();
    exp_q.delete();
    RESETN = 1'b0;
    rel = cyc;
    expect_init(rel);
    wait_ready(READY_AT + 50, rdy, gseen);
    check("rerun_ready_cycle", rdy - rel, READY_AT);
    check("rerun_no_early_gnt", gseen, 0);
    wait_gnt(100, who, at);
    check("pending_winner", who, 1);
    check("pending_gnt_cycle", at - rel, READY_AT + 1);
    expect_xfer(1'b0, TEXT1, at);
    REQ1 = 1'b0;
    wait_done(XFER + 50, done_at);
    check("pending_len", done_at - at, XFER);
    check_bus("pending");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
